// File: rtl/cic_comp_fir_pkg.sv
// cic_comp_fir_pkg: widths, compensation coefficients, state encoding and output scaling (CIC_COMP_SAT_EN selects saturate vs wrap)
package cic_comp_pkg;
  localparam int TAPS = 15;
  localparam int IN_W = 8;
  localparam int COEF_W = 12;
  localparam int OUT_W = 8;
  localparam int ACC_W = 24;
  localparam int SHIFT = 11;
  localparam int PTR_W = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  localparam coef_t COMP_COEF [TAPS] = '{
    -12'sd4, -12'sd10, 12'sd14, 12'sd30, -12'sd60, -12'sd100, 12'sd170, 12'sd1968,
    12'sd170, -12'sd100, -12'sd60, 12'sd30, 12'sd14, -12'sd10, -12'sd4
  };
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (OUT_W - 1)));
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef CIC_COMP_SAT_EN
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    return s > SMAX ? OUT_W'(SMAX) : s < SMIN ? OUT_W'(SMIN) : OUT_W'(s);
`else
    return OUT_W'(a >>> SHIFT);
`endif
  endfunction
endpackage

// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: sample-in / filtered-out bundle between the CIC stage and the compensation filter
interface cic_comp_fir_if;
  import cic_comp_pkg::*;
  logic signed [IN_W-1:0] d_in;
  logic d_clk;
  logic signed [OUT_W-1:0] d_out;
  logic d_valid;
  logic busy;
  logic overrun;
  modport master (output d_in, d_clk, input d_out, d_valid, busy, overrun);
  modport slave (input d_in, d_clk, output d_out, d_valid, busy, overrun);
endinterface

// File: rtl/cic_comp_fir_coef_rom.sv
// cic_comp_coef_rom: combinational coefficient lookup, so the MAC reads its tap in the same cycle and latency stays TAPS+2
module cic_comp_coef_rom
  import cic_comp_pkg::*;
(
  input  logic [PTR_W-1:0] i_idx,
  output coef_t            o_coef
);
  assign o_coef = COMP_COEF[i_idx];
endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: serial-MAC CIC droop compensation FIR; combinational coef ROM, latency TAPS+2; CIC_COMP_SAT_EN saturates output instead of wrapping
module cic_comp_fir
  import cic_comp_pkg::*;
(
  input logic     clk,
  input logic     rst,
  cic_comp_fir_if.slave bus
);
  logic                    r_d_clk_q;
  logic signed [IN_W-1:0]  r_buf [TAPS];
  logic [PTR_W-1:0]        r_wr;
  logic [PTR_W-1:0]        r_rd;
  logic [PTR_W-1:0]        r_k;
  logic signed [ACC_W-1:0] r_acc;
  state_t                  r_state;
  logic signed [OUT_W-1:0] r_d_out;
  logic                    r_d_valid;
  logic                    r_busy;
  logic                    r_overrun;
  logic                    w_new;
  coef_t                   w_coef;
  logic signed [ACC_W-1:0] w_prod;
  assign w_new = bus.d_clk & ~r_d_clk_q;
  assign w_prod = ACC_W'(r_buf[r_rd]) * ACC_W'(w_coef);
  cic_comp_coef_rom u_rom (.i_idx(r_k), .o_coef(w_coef));
  // capture on d_clk rise when idle, walk taps newest-to-oldest, then emit scaled result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_clk_q <= 1'b0;
      r_buf     <= '{default: '0};
      r_wr      <= '0;
      r_rd      <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_state   <= IDLE;
      r_d_out   <= '0;
      r_d_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_d_clk_q <= bus.d_clk;
      r_d_valid <= 1'b0;
      if (w_new && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (w_new) begin
          r_buf[r_wr] <= bus.d_in;
          r_rd        <= r_wr;
          r_wr        <= r_wr == PTR_W'(TAPS - 1) ? '0 : r_wr + 1'b1;
          r_k         <= '0;
          r_acc       <= '0;
          r_busy      <= 1'b1;
          r_state     <= MAC;
        end
        MAC: begin
          r_acc <= r_acc + w_prod;
          r_rd  <= r_rd == '0 ? PTR_W'(TAPS - 1) : r_rd - 1'b1;
          r_k   <= r_k + 1'b1;
          if (r_k == PTR_W'(TAPS - 1)) begin
            r_busy  <= 1'b0;
            r_state <= OUT;
          end
        end
        OUT: begin
          r_d_out   <= scale(r_acc);
          r_d_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.d_out   = r_d_out;
  assign bus.d_valid = r_d_valid;
  assign bus.busy    = r_busy;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: random and directed stimulus against a convolution reference model
module tb_cic_comp_fir;
  localparam int NT = 15;
  localparam int CF [NT] = '{-4, -10, 14, 30, -60, -100, 170, 1968, 170, -100, -60, 30, 14, -10, -4};
  logic clk = 1'b0;
  logic rst;
  cic_comp_fir_if bus();
  cic_comp_fir dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_tot = 0;
  int n_pass = 0;
  int hist[$];
  int exp_q[$];
  int last_out = 0;
  int mon_e;
  task automatic check(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask
  function automatic int model_out();
    int acc = 0;
    for (int k = 0; k < NT; k++)
      if (k < hist.size()) acc += hist[hist.size() - 1 - k] * CF[k];
    acc = acc >>> 11;
`ifdef CIC_COMP_SAT_EN
    return acc > 127 ? 127 : acc < -128 ? -128 : acc;
`else
    acc = acc & 255;
    return acc > 127 ? acc - 256 : acc;
`endif
  endfunction
  task automatic accept(input int x);
    hist.push_back(x);
    exp_q.push_back(model_out());
  endtask
  task automatic send(input int x, input int hi, input int lo);
    bus.d_in = 8'(x);
    bus.d_clk = 1'b1;
    accept(x);
    repeat (hi) @(posedge clk);
    #1 bus.d_clk = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask
  task automatic drain(input string tag);
    repeat (30) @(posedge clk);
    #1 check(tag, exp_q.size(), 0);
  endtask
  task automatic impulse(input string tag);
    int lat;
    lat = 0;
    bus.d_in = 8'sd127;
    bus.d_clk = 1'b1;
    accept(127);
    while (lat < 40 && !bus.d_valid) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, 17);
    @(posedge clk);
    #1 check({tag, "_valid_width"}, int'(bus.d_valid), 0);
    bus.d_clk = 1'b0;
    repeat (64 - 19) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) send(0, 32, 32);
    drain({tag, "_drain"});
  endtask
  always @(negedge clk) begin
    if (bus.d_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("d_out", int'($signed(bus.d_out)), mon_e);
      end
      last_out = int'($signed(bus.d_out));
    end
  end
  initial begin
    logic [7:0] rb;
    bus.d_in = '0;
    bus.d_clk = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_out", int'(bus.d_out), 0);
    check("rst_d_valid", int'(bus.d_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    impulse("impulse");
    for (int i = 0; i < 40; i++) send(64, 10, 10);
    drain("dc_drain");
    check("dc_steady", last_out, 64);
    for (int i = 0; i < NT; i++) send(CF[NT - 1 - i] < 0 ? -127 : 127, 10, 10);
    drain("sat_pos_drain");
`ifdef CIC_COMP_SAT_EN
    check("sat_pos", last_out, 127);
`else
    check("wrap_pos", last_out, -86);
`endif
    for (int i = 0; i < NT; i++) send(CF[NT - 1 - i] < 0 ? 127 : -127, 10, 10);
    drain("sat_neg_drain");
`ifdef CIC_COMP_SAT_EN
    check("sat_neg", last_out, -128);
`else
    check("wrap_neg", last_out, 85);
`endif
    for (int i = 1; i <= 3 * NT; i++) send(i, 10, 10);
    drain("ramp_drain");
    for (int i = 0; i < 30; i++) begin
      rb = 8'($urandom_range(255));
      send(int'($signed(rb)), 8, 10 + int'($urandom_range(20)));
    end
    drain("rand_drain");
    check("no_overrun_yet", int'(bus.overrun), 0);
    bus.d_in = 8'sd50;
    bus.d_clk = 1'b1;
    accept(50);
    repeat (2) @(posedge clk);
    #1 bus.d_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.d_in = -8'sd90;
    bus.d_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("overrun_set", int'(bus.overrun), 1);
    bus.d_clk = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(10 * i - 20, 10, 10);
    drain("overrun_drain");
    check("overrun_sticky", int'(bus.overrun), 1);
    bus.d_in = 8'sd100;
    bus.d_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.d_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("mac_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_d_out", int'(bus.d_out), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_overrun", int'(bus.overrun), 0);
    check("mid_rst_valid", int'(bus.d_valid), 0);
    rst = 1'b0;
    hist.delete();
    drain("mid_rst_quiet");
    impulse("impulse2");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
